// File: rtl/stack_exerciser_pkg.sv
// rtl/stack_exerciser_pkg.sv - shared states, constants and helpers for the stack self-test initiator
package stack_exerciser_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PUSH,
        PUSH_WAIT,
        OVF,
        PEEK,
        POP,
        POP_WAIT,
        UNF,
        DONE
    } state_t;

    localparam logic [8:0] OVF_IDX  = 9'h100;
    localparam logic [8:0] UNF_IDX  = 9'h101;
    localparam logic [8:0] NO_FAIL  = 9'h1FF;
    localparam logic [7:0] OVF_DATA = 8'hA5;

    // Failure counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/stack_exerciser_settle_timer.sv
// rtl/stack_exerciser_settle_timer.sv - loadable down-counter pacing the stack settle windows
module settle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins; otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/stack_exerciser.sv
// rtl/stack_exerciser.sv - push/pop self-test initiator for the LIFO stack
module stack_exerciser
    import stack_exerciser_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int SETTLE    = 1,
    parameter int CHECK_ERR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seed,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_data,
    input  logic [7:0] stk_q,
    input  logic       stk_error,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [8:0] first_fail
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam int TW = 5;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    // Push wait spends SETTLE idle cycles plus the sampling cycle. Pop wait
    // spends only SETTLE cycles because the following PEEK does the sampling.
    // Probes keep one extra guard cycle before looking at the error flag.
    localparam logic [TW-1:0] PUSH_WAIT_V = TW'(SETTLE);
    localparam logic [TW-1:0] POP_WAIT_V  = TW'(SETTLE - 1);
    localparam logic [TW-1:0] PROBE_V     = TW'(SETTLE + 1);

    state_t        state_q, state_d;
    logic [7:0]    seed_q, seed_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          probe_wait_q, probe_wait_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [8:0]    first_fail_q, first_fail_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;
    logic          fail;
    logic [8:0]    fail_idx;
    logic [7:0]    pattern;
    logic [7:0]    exp_peek;

    settle_timer #(.W(TW)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign pattern  = seed_q + 8'(idx_q);
    assign exp_peek = seed_q + 8'(DEPTH - 1) - 8'(idx_q);

    // Next-state, stack strobes and failure recording.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        idx_d        = idx_q;
        probe_wait_d = probe_wait_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_data     = 8'h00;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        fail         = 1'b0;
        fail_idx     = NO_FAIL;

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d       = seed;
                    err_count_d  = 8'h00;
                    first_fail_d = NO_FAIL;
                    idx_d        = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = PUSH;
                end
            end
            PUSH: begin
                stk_push = 1'b1;
                stk_data = pattern;
                tmr_load = 1'b1;
                tmr_val  = PUSH_WAIT_V;
                state_d  = PUSH_WAIT;
            end
            PUSH_WAIT: begin
                if (tmr_expired) begin
                    if (stk_error) begin
                        fail     = 1'b1;
                        fail_idx = 9'(idx_q);
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (CHECK_ERR != 0) ? OVF : PEEK;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = PUSH;
                    end
                end
            end
            OVF: begin
                if (!probe_wait_q) begin
                    stk_push     = 1'b1;
                    stk_data     = OVF_DATA;
                    tmr_load     = 1'b1;
                    tmr_val      = PROBE_V;
                    probe_wait_d = 1'b1;
                end else if (tmr_expired) begin
                    if (!stk_error) begin
                        fail     = 1'b1;
                        fail_idx = OVF_IDX;
                    end
                    probe_wait_d = 1'b0;
                    state_d      = PEEK;
                end
            end
            PEEK: begin
                if (stk_q != exp_peek) begin
                    fail     = 1'b1;
                    fail_idx = 9'(idx_q);
                end
                state_d = POP;
            end
            POP: begin
                stk_pop  = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = POP_WAIT_V;
                state_d  = POP_WAIT;
            end
            POP_WAIT: begin
                if (tmr_expired) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (CHECK_ERR != 0) ? UNF : DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = PEEK;
                    end
                end
            end
            UNF: begin
                if (!probe_wait_q) begin
                    stk_pop      = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = PROBE_V;
                    probe_wait_d = 1'b1;
                end else if (tmr_expired) begin
                    if (!stk_error) begin
                        fail     = 1'b1;
                        fail_idx = UNF_IDX;
                    end
                    probe_wait_d = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count_q == 8'h00);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
            err_count_d = sat_inc(err_count_q);
            if (first_fail_q == NO_FAIL) begin
                first_fail_d = fail_idx;
            end
        end
    end

    // State and result registers; reset aborts any run in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            seed_q       <= 8'h00;
            idx_q        <= '0;
            probe_wait_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 8'h00;
            first_fail_q <= NO_FAIL;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            idx_q        <= idx_d;
            probe_wait_q <= probe_wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_stack_exerciser.sv
// tb/tb_stack_exerciser.sv - self-checking bench for stack_exerciser with a behavioural LIFO model
module tb_stack_exerciser;

    localparam int DEPTH  = 32;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [7:0] seed;
    int mode;  // 0 good stack, 1 corrupts the value seen at pop step 5, 2 never flags error

    logic [1:0]      push_w, pop_w, err_w, busy_w, done_w, pass_w;
    logic [1:0][7:0] data_w, q_w, errc_w;
    logic [1:0][8:0] ff_w;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int n_push, n_pop, n_overlap, lat0, lat1;

    always #5 clk = ~clk;

    stack_exerciser #(.DEPTH(DEPTH), .SETTLE(SETTLE), .CHECK_ERR(1)) u_dut (
        .clk(clk), .reset(rst), .start(start), .seed(seed),
        .stk_push(push_w[0]), .stk_pop(pop_w[0]), .stk_data(data_w[0]),
        .stk_q(q_w[0]), .stk_error(err_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(errc_w[0]), .first_fail(ff_w[0])
    );

    stack_exerciser #(.DEPTH(DEPTH), .SETTLE(SETTLE), .CHECK_ERR(0)) u_dut_nc (
        .clk(clk), .reset(rst), .start(start), .seed(seed),
        .stk_push(push_w[1]), .stk_pop(pop_w[1]), .stk_data(data_w[1]),
        .stk_q(q_w[1]), .stk_error(err_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(errc_w[1]), .first_fail(ff_w[1])
    );

    // One behavioural LIFO per DUT.
    for (genvar g = 0; g < 2; g++) begin : g_stk
        logic [7:0] mem [DEPTH];
        logic [6:0] cnt;
        logic       err;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (push_w[g]) begin
                if (cnt == 7'(DEPTH)) begin
                    err <= (mode != 2);
                end else begin
                    mem[cnt[4:0]] <= data_w[g];
                    cnt <= cnt + 7'd1;
                    err <= 1'b0;
                end
            end else if (pop_w[g]) begin
                if (cnt == 7'd0) begin
                    err <= (mode != 2);
                end else begin
                    cnt <= cnt - 7'd1;
                    err <= 1'b0;
                end
            end
        end
        assign q_w[g]   = (cnt == 7'd0) ? 8'h00 :
                          (mode == 1 && cnt == 7'(DEPTH - 5)) ? 8'h00 :
                          mem[5'(cnt - 7'd1)];
        assign err_w[g] = err;
    end

    // Runs one self-test; the push-data scoreboard is filled up front and
    // drained as the DUT strobes its pushes.
    task automatic run(input logic [7:0] s, input int extra_at);
        logic [7:0] e;
        int cyc;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            e = s + 8'(i);
            exp_q.push_back(e);
        end
        exp_q.push_back(8'hA5);
        n_push = 0; n_pop = 0; n_overlap = 0; lat0 = 0; lat1 = 0; cyc = 0;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        while ((lat0 == 0 || lat1 == 0) && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == extra_at);
            if (push_w[0]) begin
                n_push++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL push_data: got extra push of %h, required none", data_w[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (data_w[0] !== e) begin
                        errors++;
                        $display("FAIL push_data: got %h, required %h (cycle %0d)", data_w[0], e, cyc);
                    end
                end
            end
            if (pop_w[0]) n_pop++;
            if (push_w[0] && pop_w[0]) n_overlap++;
            if (done_w[0] && lat0 == 0) lat0 = cyc;
            if (done_w[1] && lat1 == 0) lat1 = cyc;
        end
        start = 1'b0;
        checks++;
        if (lat0 == 0 || lat1 == 0) begin
            errors++;
            $display("FAIL run_timeout: done0=%0d done1=%0d, required both done within 1000 cycles", lat0, lat1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL push_missing: %0d pushes outstanding, required 0", exp_q.size());
        end
        checks++;
        if (n_overlap != 0) begin
            errors++;
            $display("FAIL push_pop_overlap: %0d cycles, required 0", n_overlap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed = 8'h00; mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_w[0], done_w[0], pass_w[0], push_w[0], pop_w[0]} !== 5'b0 || errc_w[0] !== 8'h00 || data_w[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b push=%b pop=%b err=%h data=%h, required all 0",
                     busy_w[0], done_w[0], pass_w[0], push_w[0], pop_w[0], errc_w[0], data_w[0]);
        end
        checks++;
        if (ff_w[0] !== 9'h1FF) begin
            errors++;
            $display("FAIL reset_first_fail: got %h, required 1ff", ff_w[0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_run();
        mode = 0;
        run(8'h10, 0);
        checks++;
        if (lat0 != 202) begin
            errors++;
            $display("FAIL good_latency: got %0d, required 202", lat0);
        end
        checks++;
        if (pass_w[0] !== 1'b1 || errc_w[0] !== 8'h00 || ff_w[0] !== 9'h1FF || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL good_result: pass=%b err=%h ff=%h busy=%b, required 1/00/1ff/0",
                     pass_w[0], errc_w[0], ff_w[0], busy_w[0]);
        end
        checks++;
        if (n_push != 33 || n_pop != 33) begin
            errors++;
            $display("FAIL good_strobes: push=%0d pop=%0d, required 33/33", n_push, n_pop);
        end
        checks++;
        if (lat1 != 194 || pass_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL nocheck_good: latency=%0d pass=%b, required 194/1", lat1, pass_w[1]);
        end
    endtask

    task automatic test_wrap(input logic [7:0] s);
        mode = 0;
        run(s, 0);
        checks++;
        if (pass_w[0] !== 1'b1 || errc_w[0] !== 8'h00 || ff_w[0] !== 9'h1FF) begin
            errors++;
            $display("FAIL wrap_result seed=%h: pass=%b err=%h ff=%h, required 1/00/1ff",
                     s, pass_w[0], errc_w[0], ff_w[0]);
        end
    endtask

    task automatic test_corrupt();
        mode = 1;
        run(8'h10, 0);
        checks++;
        if (pass_w[0] !== 1'b0 || errc_w[0] !== 8'd1 || ff_w[0] !== 9'd5) begin
            errors++;
            $display("FAIL corrupt_result: pass=%b err=%h ff=%h, required 0/01/005",
                     pass_w[0], errc_w[0], ff_w[0]);
        end
        mode = 0;
    endtask

    task automatic test_no_error();
        mode = 2;
        run(8'h40, 0);
        checks++;
        if (pass_w[0] !== 1'b0 || errc_w[0] !== 8'd2 || ff_w[0] !== 9'h100) begin
            errors++;
            $display("FAIL noerr_result: pass=%b err=%h ff=%h, required 0/02/100",
                     pass_w[0], errc_w[0], ff_w[0]);
        end
        checks++;
        if (pass_w[1] !== 1'b1 || errc_w[1] !== 8'd0 || ff_w[1] !== 9'h1FF) begin
            errors++;
            $display("FAIL noerr_nocheck: pass=%b err=%h ff=%h, required 1/00/1ff",
                     pass_w[1], errc_w[1], ff_w[1]);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        @(negedge clk);
        seed  = 8'h77;
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: got %b before reset, required 1", busy_w[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_w[0], done_w[0], pass_w[0], push_w[0], pop_w[0]} !== 5'b0 || errc_w[0] !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset_outputs: busy=%b done=%b pass=%b push=%b pop=%b err=%h, required all 0",
                     busy_w[0], done_w[0], pass_w[0], push_w[0], pop_w[0], errc_w[0]);
        end
        checks++;
        if (ff_w[0] !== 9'h1FF) begin
            errors++;
            $display("FAIL midrun_reset_ff: got %h, required 1ff", ff_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        run(8'h10, 0);
        checks++;
        if (pass_w[0] !== 1'b1 || lat0 != 202) begin
            errors++;
            $display("FAIL after_reset_run: pass=%b latency=%0d, required 1/202", pass_w[0], lat0);
        end
    endtask

    task automatic test_back_to_back();
        mode = 0;
        run(8'h20, 20);
        checks++;
        if (n_push != 33 || n_pop != 33) begin
            errors++;
            $display("FAIL restart_strobes: push=%0d pop=%0d, required 33/33", n_push, n_pop);
        end
        checks++;
        if (pass_w[0] !== 1'b1 || lat0 != 202) begin
            errors++;
            $display("FAIL restart_result: pass=%b latency=%0d, required 1/202", pass_w[0], lat0);
        end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_wrap(8'hF0);
        test_wrap(8'hFF);
        test_corrupt();
        test_no_error();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_exerciser.md
Name: stack_exerciser

Overview:
Self-test initiator for the LIFO stack; replaces the debounced push/pop switches as the stack's command source.
- Pushes DEPTH bytes of a seeded incrementing pattern and probes overflow.
- Pops and compares every byte in reverse order, then probes underflow.
- Reports pass/fail, mismatch count and first failing index.
- Sits in the stack top level beside the stack, muxed ahead of its push/pop/data_in inputs.

Parameters:
DEPTH, 32, stack capacity in entries; must equal the stack's depth; power of two, 2..256
SETTLE, 1, idle cycles after each push/pop before the stack's outputs are sampled; 1..15
CHECK_ERR, 1, 1 = run overflow/underflow probes and require error; 0 = skip both probes

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a run; ignored while busy=1
seed  input  8  pattern base value; sampled when start is accepted
stk_push  output  1  push strobe to stack, one cycle wide
stk_pop  output  1  pop strobe to stack, one cycle wide
stk_data  output  8  data to stack data_in; valid in the cycle stk_push=1
stk_q  input  8  stack data_out (current top of stack)
stk_error  input  1  stack error flag
busy  output  1  run in progress
done  output  1  high from run end until the next accepted start
pass  output  1  valid when done=1; 1 = zero mismatches and all error checks met
err_count  output  8  number of failed checks, saturating at 255
first_fail  output  9  index of first failed check; 0x1FF if none

Behaviour:
Reset (async, active-high): all outputs 0, except first_fail=0x1FF. FSM returns to IDLE. seed_r and the index counter clear. Reset mid-run aborts the run with no residual strobe.

Pattern: word i = (seed_r + i) mod 256, for i = 0..DEPTH-1. On pop step k (k = 0..DEPTH-1), the expected value is (seed_r + DEPTH-1-k) mod 256.

Stack contract:
- stk_q shows the top entry; it is valid SETTLE cycles after any push or pop.
- stk_error is sampled SETTLE cycles after the probe strobe.
- stk_push and stk_pop are never asserted in the same cycle.

FSM:
- IDLE: on start, latch seed; clear err_count, first_fail=0x1FF, idx=0, done=0; busy=1; go to PUSH.
- PUSH: stk_push=1, stk_data=pattern(idx), for one cycle; go to PUSH_WAIT.
- PUSH_WAIT: count SETTLE cycles.
  - If stk_error=1 here, record a failure at index idx.
  - If idx=DEPTH-1: idx=0, then go to OVF (CHECK_ERR=1) or PEEK (CHECK_ERR=0).
  - Otherwise idx++ and go to PUSH.
- OVF: stk_push=1 with data 0xA5; then wait SETTLE cycles. stk_error must be 1, else record a failure at index 0x100. Go to PEEK.
- PEEK: compare stk_q with expected(idx); on mismatch record a failure at index idx. Go to POP.
- POP: stk_pop=1 for one cycle; go to POP_WAIT.
- POP_WAIT: count SETTLE cycles.
  - If idx=DEPTH-1: go to UNF (CHECK_ERR=1) or DONE (CHECK_ERR=0).
  - Otherwise idx++ and go to PEEK.
- UNF: stk_pop=1; then wait SETTLE cycles. stk_error must be 1, else record a failure at index 0x101. Go to DONE.
- DONE (one cycle): busy=0, done=1, pass=(err_count==0); go to IDLE. done, pass, err_count and first_fail hold until the next accepted start.

Recording a failure: err_count increments, saturating at 255. first_fail is written only while it is 0x1FF.

Widths: idx is $clog2(DEPTH)+1 bits. Pattern arithmetic is 8-bit and wraps. The overflow probe's 0xA5 must not be counted as a pattern check.

Boundaries:
- start while busy: ignored.
- start in the same cycle as the DONE state: ignored; must reassert in IDLE.
- DEPTH=2 is legal.
- seed=0xFF: the pattern wraps to 0x00 at i=1.

Latency: DEPTH*(2+SETTLE)*2 plus probe cycles plus 2.
- DEPTH=32, SETTLE=1, CHECK_ERR=1: 32*3 pushes + 4 ovf + 32*(1+1+1) pops + 4 unf + 2 = 202 cycles from start to done.

Decomposition:
Shared package holds:
- FSM state enum: IDLE, PUSH, PUSH_WAIT, OVF, PEEK, POP, POP_WAIT, UNF, DONE
- constants OVF_IDX=9'h100, UNF_IDX=9'h101, NO_FAIL=9'h1FF, OVF_DATA=8'hA5

The settle counter is a small sub-module, settle_timer (load/expire), reused by all three wait states. Everything else stays in one module.

Test Plan:
- Good stack, DEPTH=32, seed=0x10, start → stk_data 0x10..0x2F on pushes; pops see 0x2F..0x10; done at cycle 202; pass=1, err_count=0, first_fail=0x1FF.
- seed=0xF0 → pattern wraps 0xFF→0x00 at i=16; pass=1.
- Stack model corrupts entry 5 (returns 0x00) → err_count=1, first_fail=5, pass=0.
- Stack never asserts error → err_count=2, first_fail=0x100, pass=0. With CHECK_ERR=0 the same model gives pass=1.
- Assert reset at cycle 50 mid-run → outputs immediately 0 and first_fail=0x1FF. A new start then completes a full run with pass=1.
- Second start pulse at cycle 20 of a run → ignored; exactly 33 push strobes and 33 pop strobes in total.
